// File: rtl/vc_switch_allocator.sv
// Separable per-VC switch allocator: round-robin VC pick per input, then round-robin input pick per output.
// Grants are registered, so there is one cycle of latency. Define SA_ISLIP_EN to advance input pointers only on a full grant.
module vc_switch_allocator #(
    parameter int PORT_NUM  = 5,
    parameter int VC_NUM    = 2,
    parameter int VC_SIZE   = $clog2(VC_NUM),
    parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 switch_request [PORT_NUM][VC_NUM],
    input  logic [PORT_SIZE-1:0] out_port       [PORT_NUM][VC_NUM],
    input  logic                 out_ready      [PORT_NUM],
    output logic                 valid_sel      [PORT_NUM],
    output logic [VC_SIZE-1:0]   vc_sel         [PORT_NUM],
    output logic                 xbar_valid     [PORT_NUM],
    output logic [PORT_SIZE-1:0] xbar_sel       [PORT_NUM]
);

    typedef logic [PORT_SIZE-1:0] port_t;
    typedef logic [VC_SIZE-1:0]   vc_t;

    vc_t   in_ptr  [PORT_NUM];
    port_t out_ptr [PORT_NUM];

    logic  elig    [PORT_NUM][VC_NUM];
    logic  s1_vld  [PORT_NUM];
    vc_t   s1_vc   [PORT_NUM];
    port_t s1_port [PORT_NUM];
    logic  s2_vld  [PORT_NUM];
    port_t s2_sel  [PORT_NUM];
    logic  in_gnt  [PORT_NUM];

    function automatic int incr_mod(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

    // Stage 1: eligibility (in-range target with credit) and per-input VC arbitration
    always_comb begin
        int   idx;
        logic rdy;
        idx = 0;
        rdy = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rdy = 1'b0;
                for (int o = 0; o < PORT_NUM; o++) begin
                    if (int'(out_port[i][v]) == o) rdy = out_ready[o];
                end
                elig[i][v] = switch_request[i][v] && rdy;
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            s1_vld[i]  = 1'b0;
            s1_vc[i]   = '0;
            s1_port[i] = '0;
            for (int off = 0; off < VC_NUM; off++) begin
                idx = int'(in_ptr[i]) + off;
                if (idx >= VC_NUM) idx = idx - VC_NUM;
                if (!s1_vld[i] && elig[i][idx]) begin
                    s1_vld[i]  = 1'b1;
                    s1_vc[i]   = vc_t'(idx);
                    s1_port[i] = out_port[i][idx];
                end
            end
        end
    end

    // Stage 2: per-output arbitration among stage-1 winners targeting it
    always_comb begin
        int j;
        j = 0;
        for (int i = 0; i < PORT_NUM; i++) in_gnt[i] = 1'b0;
        for (int o = 0; o < PORT_NUM; o++) begin
            s2_vld[o] = 1'b0;
            s2_sel[o] = '0;
            for (int off = 0; off < PORT_NUM; off++) begin
                j = int'(out_ptr[o]) + off;
                if (j >= PORT_NUM) j = j - PORT_NUM;
                if (!s2_vld[o] && s1_vld[j] && int'(s1_port[j]) == o) begin
                    s2_vld[o] = 1'b1;
                    s2_sel[o] = port_t'(j);
                    in_gnt[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                valid_sel[i]  <= 1'b0;
                vc_sel[i]     <= '0;
                xbar_valid[i] <= 1'b0;
                xbar_sel[i]   <= '0;
                in_ptr[i]     <= '0;
                out_ptr[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < PORT_NUM; i++) begin
                valid_sel[i] <= in_gnt[i];
                vc_sel[i]    <= in_gnt[i] ? s1_vc[i] : '0;
`ifdef SA_ISLIP_EN
                // A stage-1 winner that loses the output keeps priority at its input
                if (in_gnt[i]) in_ptr[i] <= vc_t'(incr_mod(int'(s1_vc[i]), VC_NUM));
`else
                if (s1_vld[i]) in_ptr[i] <= vc_t'(incr_mod(int'(s1_vc[i]), VC_NUM));
`endif
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                xbar_valid[o] <= s2_vld[o];
                xbar_sel[o]   <= s2_sel[o];
                if (s2_vld[o]) out_ptr[o] <= port_t'(incr_mod(int'(s2_sel[o]), PORT_NUM));
            end
        end
    end

endmodule

// File: tb/tb_vc_switch_allocator.sv
// Directed checks of the VC switch allocator with immediate assertions and hand-computed expectations.
module tb_vc_switch_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic       switch_request [5][2];
    logic [2:0] out_port       [5][2];
    logic       out_ready      [5];
    logic       valid_sel      [5];
    logic [0:0] vc_sel         [5];
    logic       xbar_valid     [5];
    logic [2:0] xbar_sel       [5];

    int n_chk  = 0;
    int n_fail = 0;

    vc_switch_allocator #(.PORT_NUM(5), .VC_NUM(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .switch_request (switch_request),
        .out_port       (out_port),
        .out_ready      (out_ready),
        .valid_sel      (valid_sel),
        .vc_sel         (vc_sel),
        .xbar_valid     (xbar_valid),
        .xbar_sel       (xbar_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        for (int i = 0; i < 5; i++) begin
            out_ready[i] = 1'b1;
            for (int v = 0; v < 2; v++) begin
                switch_request[i][v] = 1'b0;
                out_port[i][v]       = 3'd0;
            end
        end
    endtask

    task automatic req(input int i, input int v, input int p);
        switch_request[i][v] = 1'b1;
        out_port[i][v]       = 3'(p);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    function automatic int n_valid_sel();
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(valid_sel[i]);
        return n;
    endfunction

    function automatic int n_xbar_valid();
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(xbar_valid[i]);
        return n;
    endfunction

    initial begin
        // Reset held with requests present: outputs stay 0
        rst = 1'b1;
        clear_req();
        req(0, 0, 1); req(0, 1, 1); req(1, 0, 1);
        #2;
        chk("rst_valid_cnt", 32'(n_valid_sel()), 0);
        chk("rst_xbar_cnt", 32'(n_xbar_valid()), 0);
        tick();
        chk("rst_hold_xbar_cnt", 32'(n_xbar_valid()), 0);
        rst = 1'b0;
        tick();
        chk("first_valid0", 32'(valid_sel[0]), 1);
        chk("first_vc0", 32'(vc_sel[0]), 0);
        chk("first_xbar1", 32'(xbar_sel[1]), 0);
        chk("first_valid1", 32'(valid_sel[1]), 0);
        // Mid-cycle reset clears outputs at once and restarts pointers
        rst = 1'b1;
        #1;
        chk("midrst_valid_cnt", 32'(n_valid_sel()), 0);
        chk("midrst_xbar_cnt", 32'(n_xbar_valid()), 0);
        rst = 1'b0;
        tick();
        chk("postrst_vc0", 32'(vc_sel[0]), 0);
        chk("postrst_xbar1", 32'(xbar_sel[1]), 0);
        chk("postrst_valid1", 32'(valid_sel[1]), 0);

        // Input-stage round robin: input 1, both VCs to output 3
        clear_req();
        do_reset();
        req(1, 0, 3); req(1, 1, 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_valid1", 32'(valid_sel[1]), 1);
            chk("rr_vc1", 32'(vc_sel[1]), 32'(k % 2));
            chk("rr_xbar3", 32'(xbar_sel[3]), 1);
            chk("rr_xvalid3", 32'(xbar_valid[3]), 1);
        end

        // Output contention: inputs 0,2,4 to output 2
        clear_req();
        do_reset();
        req(0, 0, 2); req(2, 0, 2); req(4, 0, 2);
        tick(); chk("cont_xbar2_a", 32'(xbar_sel[2]), 0); chk("cont_one_a", 32'(n_valid_sel()), 1);
        tick(); chk("cont_xbar2_b", 32'(xbar_sel[2]), 2); chk("cont_one_b", 32'(n_valid_sel()), 1);
        chk("cont_valid2", 32'(valid_sel[2]), 1);
        tick(); chk("cont_xbar2_c", 32'(xbar_sel[2]), 4); chk("cont_one_c", 32'(n_valid_sel()), 1);
        tick(); chk("cont_xbar2_wrap", 32'(xbar_sel[2]), 0); chk("cont_valid0", 32'(valid_sel[0]), 1);

        // Backpressure on output 3
        clear_req();
        do_reset();
        out_ready[3] = 1'b0;
        req(0, 1, 3); req(0, 0, 1);
        tick();
        chk("bp_vc0", 32'(vc_sel[0]), 0);
        chk("bp_xbar1", 32'(xbar_sel[1]), 0);
        chk("bp_xvalid1", 32'(xbar_valid[1]), 1);
        chk("bp_xvalid3", 32'(xbar_valid[3]), 0);
        out_ready[3] = 1'b1;
        tick();
        chk("bp_rel_vc0", 32'(vc_sel[0]), 1);
        chk("bp_rel_xvalid3", 32'(xbar_valid[3]), 1);
        chk("bp_rel_xbar3", 32'(xbar_sel[3]), 0);
        chk("bp_rel_xvalid1", 32'(xbar_valid[1]), 0);

        // Pointer contrast: preload out_ptr[2]=1 with in_ptr[0] back at 0
        clear_req();
        do_reset();
        req(0, 0, 2);
        tick();
        chk("pre_a_xbar2", 32'(xbar_valid[2]), 1);
        clear_req();
        req(0, 1, 0);
        tick();
        chk("pre_b_vc0", 32'(vc_sel[0]), 1);
        clear_req();
        req(0, 0, 2); req(0, 1, 4); req(1, 0, 2);
        tick();
        chk("c1_valid0", 32'(valid_sel[0]), 0);
        chk("c1_valid1", 32'(valid_sel[1]), 1);
        chk("c1_xbar2", 32'(xbar_sel[2]), 1);
        chk("c1_xvalid4", 32'(xbar_valid[4]), 0);
        tick();
`ifdef SA_ISLIP_EN
        chk("c2_valid0", 32'(valid_sel[0]), 1);
        chk("c2_vc0", 32'(vc_sel[0]), 0);
        chk("c2_xbar2", 32'(xbar_sel[2]), 0);
        chk("c2_xvalid4", 32'(xbar_valid[4]), 0);
        chk("c2_valid1", 32'(valid_sel[1]), 0);
`else
        chk("c2_valid0", 32'(valid_sel[0]), 1);
        chk("c2_vc0", 32'(vc_sel[0]), 1);
        chk("c2_xvalid4", 32'(xbar_valid[4]), 1);
        chk("c2_xbar4", 32'(xbar_sel[4]), 0);
        chk("c2_xbar2", 32'(xbar_sel[2]), 1);
        chk("c2_valid1", 32'(valid_sel[1]), 1);
`endif

        // Out-of-range target ignored
        clear_req();
        do_reset();
        req(2, 0, 7);
        tick();
        chk("bad_valid_cnt", 32'(n_valid_sel()), 0);
        chk("bad_xbar_cnt", 32'(n_xbar_valid()), 0);
        req(3, 0, 7); req(3, 1, 4);
        tick();
        chk("bad_mix_vc3", 32'(vc_sel[3]), 1);
        chk("bad_mix_xbar4", 32'(xbar_sel[4]), 3);
        chk("bad_mix_valid2", 32'(valid_sel[2]), 0);

        // No requests: outputs return to 0
        clear_req();
        tick();
        chk("idle_valid_cnt", 32'(n_valid_sel()), 0);
        chk("idle_xbar_cnt", 32'(n_xbar_valid()), 0);

        // All inputs granted at once to distinct outputs
        do_reset();
        for (int i = 0; i < 5; i++) req(i, 1, (i + 1) % 5);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("all_valid", 32'(valid_sel[i]), 1);
            chk("all_vc", 32'(vc_sel[i]), 1);
            chk("all_xbar", 32'(xbar_sel[(i + 1) % 5]), 32'(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
